uart_parity_engine: RTL and testbench

- Bit-serial parity generator/checker for the UART datapath, parametrised in maximum data width and configurable at runtime for frame length, parity mode and direction.
- TX side (generate): accumulates parity while data bits shift out and presents the parity bit after the last data bit.
- RX side (check): accumulates parity over the received data bits, samples the received parity bit and flags a mismatch.
- Sits between the UART TX/RX shift FSMs and the frame/status logic.

---
 rtl/uart_parity_engine.sv | 159 +++++++++++++++
 tb/tb_uart_parity_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_engine.sv
// Bit-serial UART parity generator (TX) and checker (RX) with runtime mode, direction and frame length.
// Optional error counter (err_count/clr_err) is compiled in when UART_PARITY_ERR_CNT_EN is defined.
module uart_parity_engine #(
  parameter int DATA_W = 9,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dir,
  input  logic [LEN_W-1:0] data_len,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             par_valid,
  output logic             par_bit,
  output logic             par_err
`ifdef UART_PARITY_ERR_CNT_EN
  ,
  input  logic             clr_err,
  output logic [7:0]       err_count
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCUM    = 2'd1;
  localparam logic [1:0] WAIT_PAR = 2'd2;

  localparam logic [2:0] MODE_EVEN  = 3'b001;
  localparam logic [2:0] MODE_ODD   = 3'b010;
  localparam logic [2:0] MODE_MARK  = 3'b011;
  localparam logic [2:0] MODE_SPACE = 3'b100;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [1:0]       state;
  logic [2:0]       mode_q;
  logic             dir_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             acc;

  logic [LEN_W-1:0] len_clamped;
  logic             acc_next;
  logic             last_bit;
  logic             parity_on;
  logic             check_frame;
  logic             exp_final;
  logic             exp_wait;

  // Expected parity bit for a given mode; reserved codes behave as "none".
  function automatic logic expected_parity(input logic [2:0] m, input logic a);
    case (m)
      MODE_EVEN:  return a;
      MODE_ODD:   return ~a;
      MODE_MARK:  return 1'b1;
      MODE_SPACE: return 1'b0;
      default:    return 1'b0;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    len_clamped = data_len;
    if (data_len < MIN_LEN)
      len_clamped = MIN_LEN;
    else if (data_len > MAX_LEN)
      len_clamped = MAX_LEN;
  end

  always_comb begin
    parity_on = 1'b0;
    case (mode_q)
      MODE_EVEN, MODE_ODD, MODE_MARK, MODE_SPACE: parity_on = 1'b1;
      default:                                    parity_on = 1'b0;
    endcase
  end

  assign acc_next    = acc ^ bit_in;
  assign last_bit    = (cnt == (len_q - ONE));
  assign check_frame = dir_q & parity_on;
  assign exp_final   = expected_parity(mode_q, acc_next);
  assign exp_wait    = expected_parity(mode_q, acc);
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 3'b000;
      dir_q     <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      acc       <= 1'b0;
      par_valid <= 1'b0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_valid <= 1'b0;
      // start wins over everything, including a coincident bit and a frame in flight.
      if (start) begin
        state   <= ACCUM;
        mode_q  <= mode;
        dir_q   <= dir;
        len_q   <= len_clamped;
        cnt     <= '0;
        acc     <= 1'b0;
        par_bit <= 1'b0;
        par_err <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          ACCUM: begin
            if (bit_valid) begin
              acc <= acc_next;
              cnt <= cnt + ONE;
              if (last_bit) begin
                if (check_frame) begin
                  state <= WAIT_PAR;
                end else begin
                  state     <= IDLE;
                  par_valid <= 1'b1;
                  par_bit   <= exp_final;
                  par_err   <= 1'b0;
                end
              end
            end
          end
          WAIT_PAR: begin
            if (bit_valid) begin
              state     <= IDLE;
              par_valid <= 1'b1;
              par_bit   <= exp_wait;
              par_err   <= bit_in ^ exp_wait;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_PARITY_ERR_CNT_EN
  // Counts reported errors as they are strobed out; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= 8'd0;
    else if (clr_err)
      err_count <= 8'd0;
    else if (par_valid && par_err && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: directed scenarios plus randomized frames
// checked against a popcount-based parity model.
module tb_uart_parity_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] mode;
  logic       dir;
  logic [3:0] data_len;
  logic       bit_valid;
  logic       bit_in;
  logic       busy;
  logic       par_valid;
  logic       par_bit;
  logic       par_err;
  logic       clr_err;
`ifdef UART_PARITY_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int passed = 0;
  int total  = 0;
  int pv_count = 0;

  uart_parity_engine #(.DATA_W(9), .LEN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .dir       (dir),
    .data_len  (data_len),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .busy      (busy),
    .par_valid (par_valid),
    .par_bit   (par_bit),
    .par_err   (par_err)
`ifdef UART_PARITY_ERR_CNT_EN
    ,
    .clr_err   (clr_err),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (par_valid) pv_count++;

  // Parity the line should carry for a frame holding `ones` set data bits.
  function automatic logic model_parity(input logic [2:0] m, input int ones);
    case (m)
      3'd1:    return logic'(ones % 2);
      3'd2:    return logic'(1 - (ones % 2));
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic s, input logic bv, input logic b);
    start = s; bit_valid = bv; bit_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] m, input logic d, input logic [3:0] len_in,
                           input logic [8:0] data, input logic rx_p, input int max_gap,
                           input logic start_bv, input logic chain, input logic clr_end,
                           input string name);
    int   eff_len;
    int   ones;
    int   pv0;
    logic none;
    logic chk;
    logic exp_b;
    logic exp_e;
    eff_len = (len_in < 5) ? 5 : ((len_in > 9) ? 9 : int'(len_in));
    ones = 0;
    for (int i = 0; i < eff_len; i++) ones += int'(data[i]);
    none  = (m == 3'd0) || (m > 3'd4);
    chk   = d && !none;
    exp_b = model_parity(m, ones);
    exp_e = chk ? (rx_p != exp_b) : 1'b0;

    mode = m; dir = d; data_len = len_in;
    step(1'b1, start_bv, 1'b1);
    mode = $urandom; dir = $urandom; data_len = $urandom;
    total++;
    if ({busy, par_valid, par_bit, par_err} !== 4'b1000)
      $display("FAIL %s start: busy/pv/bit/err=%b want 1000", name, {busy, par_valid, par_bit, par_err});
    else passed++;

    pv0 = pv_count;
    for (int i = 0; i < eff_len; i++) begin
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, data[i]);
    end
    if (chk) begin
      total++;
      if ({par_valid, busy} !== 2'b01)
        $display("FAIL %s wait_par: pv/busy=%b want 01", name, {par_valid, busy});
      else passed++;
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, rx_p);
    end

    total++;
    if ({par_valid, busy, par_bit, par_err} !== {1'b1, 1'b0, exp_b, exp_e})
      $display("FAIL %s result: pv/busy/bit/err=%b want %b", name,
               {par_valid, busy, par_bit, par_err}, {1'b1, 1'b0, exp_b, exp_e});
    else passed++;
    total++;
    if (pv_count !== pv0)
      $display("FAIL %s early_strobe: got %0d extra par_valid pulses want 0", name, pv_count - pv0);
    else passed++;

    if (!chain) begin
      clr_err = clr_end;
      step(1'b0, 1'b0, 1'b0);
      clr_err = 1'b0;
      total++;
      if ({par_valid, par_bit, par_err} !== {1'b0, exp_b, exp_e})
        $display("FAIL %s hold: pv/bit/err=%b want %b", name, {par_valid, par_bit, par_err},
                 {1'b0, exp_b, exp_e});
      else passed++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    total++;
    if ({busy, par_valid, par_bit, par_err} !== 4'b0000)
      $display("FAIL reset: busy/pv/bit/err=%b want 0000", {busy, par_valid, par_bit, par_err});
    else passed++;
`ifdef UART_PARITY_ERR_CNT_EN
    total++;
    if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count);
    else passed++;
`endif
    // Bits while idle must neither start a frame nor strobe.
    repeat (4) step(1'b0, 1'b1, 1'b1);
    total++;
    if ({busy, par_valid} !== 2'b00 || pv_count !== 0)
      $display("FAIL idle_bits: busy/pv=%b strobes=%0d want 00/0", {busy, par_valid}, pv_count);
    else passed++;
  endtask

  task automatic test_generate();
    run_frame(3'd1, 1'b0, 4'd8, 9'h08F, 1'b0, 0, 1'b0, 1'b0, 1'b0, "gen_even_8f");
    run_frame(3'd2, 1'b0, 4'd8, 9'h0CF, 1'b0, 2, 1'b0, 1'b0, 1'b0, "gen_odd_cf");
    run_frame(3'd1, 1'b0, 4'd8, 9'h0CF, 1'b0, 1, 1'b0, 1'b0, 1'b0, "gen_even_cf");
    run_frame(3'd3, 1'b0, 4'd9, 9'h1FF, 1'b0, 0, 1'b0, 1'b0, 1'b0, "gen_mark_9");
  endtask

  task automatic test_check();
    run_frame(3'd1, 1'b1, 4'd8, 9'h0CF, 1'b1, 1, 1'b0, 1'b0, 1'b0, "chk_even_err");
    run_frame(3'd1, 1'b1, 4'd8, 9'h0CF, 1'b0, 1, 1'b0, 1'b0, 1'b0, "chk_even_ok");
    run_frame(3'd2, 1'b1, 4'd6, 9'h015, 1'b0, 3, 1'b0, 1'b0, 1'b0, "chk_odd_ok");
  endtask

  task automatic test_clamp_none();
    run_frame(3'd3, 1'b1, 4'd3,  9'h000, 1'b0, 0, 1'b0, 1'b0, 1'b0, "clamp_lo_mark");
    run_frame(3'd1, 1'b0, 4'd15, 9'h1AA, 1'b0, 0, 1'b0, 1'b0, 1'b0, "clamp_hi_even");
    run_frame(3'd0, 1'b1, 4'd7,  9'h07F, 1'b1, 0, 1'b0, 1'b0, 1'b0, "none_chk_7");
    run_frame(3'd6, 1'b1, 4'd5,  9'h01F, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reserved_mode");
  endtask

  task automatic test_restart_reset();
    int pv0;
    // Aborted 5-bit frame would have completed on the first bit of the new frame.
    mode = 3'd2; dir = 1'b0; data_len = 4'd5;
    pv0 = pv_count;
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, 1'b1);
    run_frame(3'd1, 1'b0, 4'd8, 9'h08F, 1'b0, 0, 1'b0, 1'b0, 1'b0, "restart");
    total++;
    if (pv_count !== pv0 + 1)
      $display("FAIL restart_single: got %0d strobes want 1", pv_count - pv0);
    else passed++;

    // A start that coincides with a bit must discard that bit.
    run_frame(3'd1, 1'b0, 4'd5, 9'h000, 1'b0, 0, 1'b1, 1'b0, 1'b0, "start_with_bit");

    mode = 3'd1; dir = 1'b1; data_len = 4'd8;
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    total++;
    if ({busy, par_valid, par_bit, par_err} !== 4'b0000)
      $display("FAIL rst_mid_frame: busy/pv/bit/err=%b want 0000", {busy, par_valid, par_bit, par_err});
    else passed++;
    pv0 = pv_count;
    repeat (7) step(1'b0, 1'b1, 1'b0);
    total++;
    if (pv_count !== pv0 || busy !== 1'b0)
      $display("FAIL rst_no_strobe: strobes=%0d busy=%b want 0/0", pv_count - pv0, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      logic [2:0] m;
      logic       d;
      logic [3:0] l;
      logic [8:0] dat;
      m   = 3'($urandom_range(7, 0));
      d   = 1'($urandom);
      l   = 4'($urandom_range(15, 0));
      dat = 9'($urandom);
      run_frame(m, d, l, dat, 1'($urandom), (k % 4), 1'($urandom), (k != 39) && ($urandom_range(1, 0) == 1),
                1'b0, $sformatf("rand%0d", k));
    end
  endtask

`ifdef UART_PARITY_ERR_CNT_EN
  task automatic test_err_count();
    clr_err = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    clr_err = 1'b0;
    for (int k = 0; k < 3; k++)
      run_frame(3'd1, 1'b1, 4'd8, 9'h0CF, 1'b1, 0, 1'b0, 1'b0, 1'b0, "err_frame");
    total++;
    if (err_count !== 8'd3) $display("FAIL err_count_3: got %0d want 3", err_count);
    else passed++;
    run_frame(3'd1, 1'b1, 4'd8, 9'h0CF, 1'b1, 0, 1'b0, 1'b0, 1'b1, "err_clr");
    total++;
    if (err_count !== 8'd0) $display("FAIL err_clr_priority: got %0d want 0", err_count);
    else passed++;
    for (int k = 0; k < 300; k++) begin
      mode = 3'd3; dir = 1'b1; data_len = 4'd5;
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'(k));
      step(1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d want 255", err_count);
    else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'd0; dir = 1'b0; data_len = 4'd0;
    bit_valid = 1'b0; bit_in = 1'b0; clr_err = 1'b0;
    #1;
    test_reset();
    test_generate();
    test_check();
    test_clamp_none();
    test_restart_reset();
    test_back_to_back();
`ifdef UART_PARITY_ERR_CNT_EN
    test_err_count();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
